vga_frame_capture: RTL and testbench

- Receive side of the VGA pixel interface that vga_test drives.
- Consumes hsync/vsync/blank/rgb qualified by a pixel strobe and rebuilds pixel coordinates.
- Writes active pixels into a linear frame-buffer write port and checks line/frame geometry against the expected active size.
- Used in on-chip loopback and self-check of the VGA generator; replaces text-dump checking.

---
 rtl/vga_frame_capture.sv | 212 +++++++++++++++++++++
 tb/tb_vga_frame_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// vga_frame_capture
//   Receive side of the VGA pixel interface. Rebuilds pixel coordinates from
//   sync/blank qualified by a pixel strobe, writes active pixels into a linear
//   frame-buffer write port and checks line/frame geometry.
//
// Ports
//   clk, reset         : single clock, synchronous active-high reset
//   pix_en             : pixel strobe; video inputs are sampled only when 1
//   hsync, vsync       : syncs, assertion level set by SYNC_POL
//   blank              : 1 = active video pixel, 0 = blanking
//   rgb                : pixel data
//   err_clr            : clears the sticky error bits
//   wr_en/addr/data    : frame-buffer write port (addr = y*H_ACTIVE + x)
//   frame_done         : one-cycle pulse at the end of each checked frame
//   frame_cnt          : completed frames, wraps
//   locked             : last completed frame had correct geometry
//   err_hlen, err_vlen : sticky line-length / line-count errors
module vga_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SYNC_POL = 0,
  parameter int RGB_W    = 24,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  input  logic [RGB_W-1:0]  rgb,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [RGB_W-1:0]  wr_data,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              locked,
  output logic              err_hlen,
  output logic              err_vlen
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] H_MAX = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_MAX = YW'(V_ACTIVE);
  localparam logic SYNC_LVL = (SYNC_POL != 0);

  typedef enum logic {SEEK, FRAME} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_vld_p0;
  logic               r_hs_p0, r_vs_p0, r_blank_p0;
  logic [RGB_W-1:0]   r_rgb_p0;
  logic               r_hs_prev, r_vs_prev, r_blank_prev;
  logic [XW-1:0]      r_x, w_x_nxt;
  logic [YW-1:0]      r_y, w_y_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_bad, w_bad_nxt;
  logic               r_wr_en_p1, w_wr_en_nxt;
  logic [ADDR_W-1:0]  r_wr_addr_p1, w_wr_addr_nxt;
  logic [RGB_W-1:0]   r_wr_data_p1, w_wr_data_nxt;
  logic               r_done_p1, w_done_nxt;
  logic [15:0]        r_frame_cnt, w_cnt_nxt;
  logic               r_locked, w_locked_nxt;
  logic               r_err_hlen, r_err_vlen;
  logic               w_hl_set, w_vl_set;
  logic               w_in_frame;
  logic               w_vs_start, w_hs_start, w_act_end;

  // ---- stage p0: input sample register ----
  always_ff @(posedge clk) begin
    if (reset) r_vld_p0 <= 1'b0;
    else       r_vld_p0 <= pix_en;
  end

  always_ff @(posedge clk) begin
    if (pix_en) begin
      r_hs_p0    <= hsync;
      r_vs_p0    <= vsync;
      r_blank_p0 <= blank;
      r_rgb_p0   <= rgb;
    end
  end

  // Edges are taken between consecutive strobed samples, never raw clocks.
  // The *_prev sync flags hold "was asserted".
  assign w_vs_start = r_vld_p0 & (r_vs_p0 == SYNC_LVL) & ~r_vs_prev;
  assign w_hs_start = r_vld_p0 & (r_hs_p0 == SYNC_LVL) & ~r_hs_prev;
  assign w_act_end  = r_vld_p0 & r_blank_prev & ~r_blank_p0;

  // ---- stage p1: framing, checks and write port ----
  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_addr_nxt    = r_addr;
    w_bad_nxt     = r_bad;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr_p1;
    w_wr_data_nxt = r_wr_data_p1;
    w_done_nxt    = 1'b0;
    w_cnt_nxt     = r_frame_cnt;
    w_locked_nxt  = r_locked;
    w_hl_set      = 1'b0;
    w_vl_set      = 1'b0;
    w_in_frame    = 1'b0;
    if (r_vld_p0) begin
      if (r_state == FRAME) begin
        // End of an active run closes the line before any frame check.
        if (w_act_end) begin
          if (r_x != H_MAX) begin
            w_hl_set  = 1'b1;
            w_bad_nxt = 1'b1;
          end
          w_x_nxt = '0;
          if (r_y != V_MAX) w_y_nxt = r_y + 1'b1;
        end else if (w_hs_start && !r_blank_p0 && !r_blank_prev) begin
          // Line without active video: re-align the column, no line counted.
          w_x_nxt = '0;
        end
        if (w_vs_start) begin
          if (w_y_nxt != V_MAX) begin
            w_vl_set  = 1'b1;
            w_bad_nxt = 1'b1;
          end
          w_done_nxt   = 1'b1;
          w_cnt_nxt    = r_frame_cnt + 16'd1;
          w_locked_nxt = !w_bad_nxt;
        end
      end
      if (w_vs_start) begin
        w_state_nxt = FRAME;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
        w_addr_nxt  = '0;
        w_bad_nxt   = 1'b0;
      end
      // A pixel on the vs_start sample already belongs to the new frame.
      w_in_frame = (r_state == FRAME) || w_vs_start;
      if (w_in_frame && r_blank_p0) begin
        if (w_x_nxt < H_MAX && w_y_nxt < V_MAX) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = w_addr_nxt;
          w_wr_data_nxt = r_rgb_p0;
          w_addr_nxt    = w_addr_nxt + 1'b1;
        end else begin
          if (w_x_nxt >= H_MAX) w_hl_set = 1'b1;
          if (w_y_nxt >= V_MAX) w_vl_set = 1'b1;
          w_bad_nxt = 1'b1;
        end
        if (w_x_nxt != H_MAX) w_x_nxt = w_x_nxt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= SEEK;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Sync history starts "asserted" so a sync already active when reset
      // releases is not mistaken for a fresh edge.
      r_hs_prev    <= 1'b1;
      r_vs_prev    <= 1'b1;
      r_blank_prev <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_bad        <= 1'b0;
      r_wr_en_p1   <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
      r_done_p1    <= 1'b0;
      r_frame_cnt  <= '0;
      r_locked     <= 1'b0;
      r_err_hlen   <= 1'b0;
      r_err_vlen   <= 1'b0;
    end else begin
      if (r_vld_p0) begin
        r_hs_prev    <= (r_hs_p0 == SYNC_LVL);
        r_vs_prev    <= (r_vs_p0 == SYNC_LVL);
        r_blank_prev <= r_blank_p0;
      end
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_addr       <= w_addr_nxt;
      r_bad        <= w_bad_nxt;
      r_wr_en_p1   <= w_wr_en_nxt;
      r_wr_addr_p1 <= w_wr_addr_nxt;
      r_wr_data_p1 <= w_wr_data_nxt;
      r_done_p1    <= w_done_nxt;
      r_frame_cnt  <= w_cnt_nxt;
      r_locked     <= w_locked_nxt;
      // A new error outranks a concurrent clear.
      r_err_hlen   <= (r_err_hlen & ~err_clr) | w_hl_set;
      r_err_vlen   <= (r_err_vlen & ~err_clr) | w_vl_set;
    end
  end

  assign wr_en      = r_wr_en_p1;
  assign wr_addr    = r_wr_addr_p1;
  assign wr_data    = r_wr_data_p1;
  assign frame_done = r_done_p1;
  assign frame_cnt  = r_frame_cnt;
  assign locked     = r_locked;
  assign err_hlen   = r_err_hlen;
  assign err_vlen   = r_err_vlen;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Testbench for vga_frame_capture: H_ACTIVE=8, V_ACTIVE=4, pix_en every 2nd clk.
// Frames are described as lists of active-run lengths; a frame-level model
// derives expected writes and frame results, a monitor compares DUT output.
module tb_vga_frame_capture;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int RW = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_en = 1'b0;
  logic          hsync = 1'b1;
  logic          vsync = 1'b1;
  logic          blank = 1'b0;
  logic [RW-1:0] rgb = '0;
  logic          err_clr = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [RW-1:0] wr_data;
  logic          frame_done;
  logic [15:0]   frame_cnt;
  logic          locked;
  logic          err_hlen;
  logic          err_vlen;

  vga_frame_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SYNC_POL(0), .RGB_W(RW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .blank(blank), .rgb(rgb), .err_clr(err_clr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .locked(locked), .err_hlen(err_hlen),
    .err_vlen(err_vlen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic [RW-1:0] data; int cyc; } wr_t;
  typedef struct { logic [15:0] cnt; logic lck; logic eh; logic ev; int cyc; } fr_t;

  wr_t wq[$];
  fr_t fq[$];
  wr_t me;
  fr_t mf;
  int  n_vec = 0;
  int  n_err = 0;

  // frame-level reference state
  bit          m_in_frame = 0;
  int          m_line = 0;
  int          m_addr = 0;
  bit          m_bad = 0;
  bit          m_eh = 0;
  bit          m_ev = 0;
  bit          m_locked = 0;
  logic [15:0] m_cnt = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or frame end.
  always @(negedge clk) begin
    if (wr_en) begin
      if (wq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wr_unexpected: got write addr=%0d data=%0h, expected none", wr_addr, wr_data);
      end else begin
        me = wq.pop_front();
        check("wr_addr", wr_addr, me.addr);
        check("wr_data", wr_data, me.data);
        check("wr_latency", cyc, me.cyc);
      end
    end
    if (frame_done) begin
      if (fq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL done_unexpected: got frame_done cnt=%0d, expected none", frame_cnt);
      end else begin
        mf = fq.pop_front();
        check("frame_cnt", frame_cnt, mf.cnt);
        check("locked", locked, mf.lck);
        check("err_hlen_at_done", err_hlen, mf.eh);
        check("err_vlen_at_done", err_vlen, mf.ev);
        check("done_latency", cyc, mf.cyc);
      end
    end
  end

  task automatic drive(input logic hs, input logic vs, input logic bl,
                       input logic [RW-1:0] d, input bit ewr, input wr_t w,
                       input bit efr, input fr_t f);
    wr_t w2;
    fr_t f2;
    @(negedge clk);
    hsync = hs; vsync = vs; blank = bl; rgb = d; pix_en = 1'b1;
    if (ewr) begin w2 = w; w2.cyc = cyc + 2; wq.push_back(w2); end
    if (efr) begin f2 = f; f2.cyc = cyc + 2; fq.push_back(f2); end
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic emit_line(input int len, input bit no_hblank);
    logic [RW-1:0] d;
    wr_t w;
    fr_t f;
    bit  ewr;
    for (int k = 0; k < len; k++) begin
      d = RW'($urandom);
      ewr = 0;
      w.addr = '0; w.data = d; w.cyc = 0;
      if (m_in_frame) begin
        if (k < H && m_line < V) begin
          ewr = 1; w.addr = AW'(m_addr); m_addr++;
        end else begin
          if (k >= H) m_eh = 1;
          if (m_line >= V) m_ev = 1;
          m_bad = 1;
        end
      end
      drive(1'b1, 1'b1, 1'b1, d, ewr, w, 1'b0, f);
    end
    if (m_in_frame && len > 0) begin
      if (len != H) begin m_eh = 1; m_bad = 1; end
      m_line++;
    end
    if (!no_hblank) begin
      drive(1'b0, 1'b1, 1'b0, '0, 1'b0, w, 1'b0, f);
      drive(1'b1, 1'b1, 1'b0, '0, 1'b0, w, 1'b0, f);
    end
  endtask

  task automatic emit_vsync();
    wr_t w;
    fr_t f;
    bit  efr = 0;
    int  yc;
    if (m_in_frame) begin
      yc = (m_line < V) ? m_line : V;
      if (yc != V) begin m_ev = 1; m_bad = 1; end
      m_cnt = m_cnt + 16'd1;
      m_locked = !m_bad;
      f.cnt = m_cnt; f.lck = m_locked; f.eh = m_eh; f.ev = m_ev; f.cyc = 0;
      efr = 1;
    end
    m_in_frame = 1; m_line = 0; m_addr = 0; m_bad = 0;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, w, efr, f);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, w, 1'b0, f);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, w, 1'b0, f);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, w, 1'b0, f);
  endtask

  task automatic run_frame(input int n, input int l0, input int l1, input int l2,
                           input int l3, input int l4, input bit last_nohb);
    int lens[5];
    lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3; lens[4] = l4;
    for (int i = 0; i < n; i++) emit_line(lens[i], last_nohb && (i == n - 1));
    emit_vsync();
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_eh = 0; m_ev = 0;
    @(negedge clk);
    check("err_hlen_clr", err_hlen, 0);
    check("err_vlen_clr", err_vlen, 0);
    check("locked_keep", locked, m_locked);
    check("cnt_keep", frame_cnt, m_cnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err_hlen"}, err_hlen, 0);
    check({tag, "_err_vlen"}, err_vlen, 0);
  endtask

  function automatic int rand_len();
    int p;
    p = $urandom_range(0, 7);
    if (p == 0) return 0;
    if (p == 1) return 7;
    if (p == 2) return 9;
    return 8;
  endfunction

  initial begin
    wr_t w;
    fr_t f;
    int  n;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, w, 1'b0, f);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, w, 1'b0, f);

    // acquisition (no frame_done), then clean frame
    emit_vsync();
    run_frame(4, 8, 8, 8, 8, 0, 1'b0);

    // short line in frame 2
    emit_line(8, 1'b0);
    emit_line(7, 1'b0);
    check("err_hlen_short", err_hlen, m_eh);
    check("err_vlen_short", err_vlen, m_ev);
    emit_line(8, 1'b0);
    emit_line(8, 1'b0);
    emit_vsync();
    clear_err();

    // long line
    run_frame(4, 8, 9, 8, 8, 0, 1'b0);
    clear_err();

    // five lines, then a clean frame
    run_frame(5, 8, 8, 8, 8, 8, 1'b0);
    clear_err();
    run_frame(4, 8, 8, 8, 8, 0, 1'b0);

    // reset in line 2
    emit_line(8, 1'b0);
    emit_line(8, 1'b0);
    emit_line(3, 1'b1);
    repeat (4) @(negedge clk);
    check("q_drained_wr", wq.size(), 0);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    m_in_frame = 0; m_line = 0; m_addr = 0; m_bad = 0;
    m_eh = 0; m_ev = 0; m_locked = 0; m_cnt = '0;
    emit_line(5, 1'b0);
    emit_line(8, 1'b0);
    emit_vsync();
    run_frame(4, 8, 8, 8, 8, 0, 1'b0);

    // last act_end on the vs_start sample
    run_frame(4, 8, 8, 8, 8, 0, 1'b1);

    // randomized frames
    for (int fr = 0; fr < 4; fr++) begin
      n = $urandom_range(3, 5);
      run_frame(n, rand_len(), rand_len(), rand_len(), rand_len(), rand_len(), 1'b0);
    end

    repeat (8) @(negedge clk);
    check("wq_empty", wq.size(), 0);
    check("fq_empty", fq.size(), 0);
    check("final_cnt", frame_cnt, m_cnt);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
